// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions and ALU-op decode for cpu_core_pipe.
// Define CPU_SHIFT_OPS_EN to enable the sll/srl opcodes; otherwise they decode as illegal.
package cpu_pkg;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_AND = 6'b000001;
  localparam logic [5:0] OP_OR  = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b000011;
  localparam logic [5:0] OP_SUB = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_XOR = 6'b000110;
  localparam logic [5:0] OP_SLL = 6'b000111;
  localparam logic [5:0] OP_SRL = 6'b001000;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

`ifdef CPU_SHIFT_OPS_EN
  localparam bit SHIFTS_EN = 1'b1;
`else
  localparam bit SHIFTS_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
    ALU_SLT, ALU_XOR, ALU_SLL, ALU_SRL, ALU_ILL
  } alu_op_e;

  function automatic alu_op_e alu_decode(input logic [5:0] op);
    case (op)
      OP_ADD:  alu_decode = ALU_ADD;
      OP_SUB:  alu_decode = ALU_SUB;
      OP_AND:  alu_decode = ALU_AND;
      OP_OR:   alu_decode = ALU_OR;
      OP_NOR:  alu_decode = ALU_NOR;
      OP_SLT:  alu_decode = ALU_SLT;
      OP_XOR:  alu_decode = ALU_XOR;
      OP_SLL:  alu_decode = SHIFTS_EN ? ALU_SLL : ALU_ILL;
      OP_SRL:  alu_decode = SHIFTS_EN ? ALU_SRL : ALU_ILL;
      default: alu_decode = ALU_ILL;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_pipe_if.sv
// Instruction valid/ready channel into cpu_core_pipe.
interface cpu_core_pipe_if;
  logic        ins_valid;
  logic [31:0] INS;
  logic        ins_ready;

  modport master (output ins_valid, INS, input ins_ready);
  modport slave  (input ins_valid, INS, output ins_ready);
endinterface

// File: rtl/cpu_alu.sv
// Combinational WIDTH-bit ALU: result, signed add/sub overflow, illegal-opcode flag.
// Shift opcodes are live only when CPU_SHIFT_OPS_EN is defined (decoded in cpu_pkg).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal
);
  localparam int SW = $clog2(WIDTH);

  alu_op_e          aop;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    aop      = alu_decode(op);
    sh       = SW'(shamt);
    sum      = a + b;
    diff     = a - b;
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (aop)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = b << sh;
      ALU_SRL: result = b >> sh;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_core_pipe.sv
// Two-stage (read / execute-writeback) CPU datapath with forwarding, manual load mode and debug read.
// Optional sll/srl opcodes are enabled by defining CPU_SHIFT_OPS_EN.
module cpu_core_pipe
  import cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LO,
  input  logic             WR,
  input  logic [AW-1:0]    RSM,
  input  logic [WIDTH-1:0] ManIn,
  cpu_core_pipe_if.slave   ins,
  input  logic             ov_clr,
  output logic             OV,
  output logic             illegal,
  output logic             retire,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  logic [WIDTH-1:0] regs [NREG];

  logic             s1_vld;
  logic [31:0]      s1_ins;
  logic             s2_vld;
  logic [5:0]       s2_op;
  logic [WIDTH-1:0] s2_a;
  logic [WIDTH-1:0] s2_b;
  logic [AW-1:0]    s2_rd;
  logic [4:0]       s2_sh;

  logic [AW-1:0]    s1_rs;
  logic [AW-1:0]    s1_rt;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;
  logic             alu_ill;
  logic             s2_wr;
  logic             accept;
  logic             man_we;
  logic             unused_ins;

  assign ins.ins_ready = LO & reset;
  assign accept        = ins.ins_valid & ins.ins_ready;
  assign man_we        = ~LO & WR;
  assign unused_ins    = ^s1_ins;

  assign s1_rs = s1_ins[RS_LSB +: AW];
  assign s1_rt = s1_ins[RT_LSB +: AW];

  // The stage-2 result bypasses the register file so back-to-back RAW needs no bubble.
  assign opnd_a = (s2_wr && (s2_rd == s1_rs)) ? alu_res : regs[s1_rs];
  assign opnd_b = (s2_wr && (s2_rd == s1_rt)) ? alu_res : regs[s1_rt];

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (s2_op),
    .a        (s2_a),
    .b        (s2_b),
    .shamt    (s2_sh),
    .result   (alu_res),
    .overflow (alu_ov),
    .illegal  (alu_ill)
  );

  assign s2_wr    = s2_vld & ~alu_ill;
  assign retire   = s2_wr;
  assign illegal  = s2_vld & alu_ill;
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      s1_vld <= 1'b0;
      s1_ins <= '0;
      s2_vld <= 1'b0;
      s2_op  <= '0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_rd  <= '0;
      s2_sh  <= '0;
      OV     <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_ins <= ins.INS;
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_op <= s1_ins[OP_LSB +: 6];
        s2_a  <= opnd_a;
        s2_b  <= opnd_b;
        s2_rd <= s1_ins[RD_LSB +: AW];
        s2_sh <= s1_ins[SH_LSB +: 5];
      end
      // Manual write is ordered last so it wins a same-register collision with a drain writeback.
      if (s2_wr)  regs[s2_rd] <= alu_res;
      if (man_we) regs[RSM]   <= ManIn;
      if (s2_vld && alu_ov) OV <= 1'b1;
      else if (ov_clr)      OV <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_core_pipe.sv
// Self-checking bench for cpu_core_pipe: opcode vector table plus pipeline corner-case sequences.
module tb_cpu_core_pipe;
  import cpu_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             LO = 1'b0;
  logic             WR = 1'b0;
  logic             ov_clr = 1'b0;
  logic [AW-1:0]    RSM = '0;
  logic [AW-1:0]    dbg_sel = '0;
  logic [WIDTH-1:0] ManIn = '0;
  logic [WIDTH-1:0] dbg_data;
  logic             OV, illegal, retire;

  cpu_core_pipe_if ins();

  always #5 clk = ~clk;

  cpu_core_pipe #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk      (clk),
    .reset    (reset),
    .LO       (LO),
    .WR       (WR),
    .RSM      (RSM),
    .ManIn    (ManIn),
    .ins      (ins),
    .ov_clr   (ov_clr),
    .OV       (OV),
    .illegal  (illegal),
    .retire   (retire),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  typedef struct {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] val;
    bit               ill;
    int               acc;
  } sb_t;

  typedef struct {
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
    logic [WIDTH-1:0] exp;
    bit               ov;
    bit               ill;
  } vec_t;

  sb_t              q[$];
  vec_t             vt[14];
  logic [WIDTH-1:0] arch [NREG];
  int               cyc = 0;
  int               n_chk = 0;
  int               n_pass = 0;
  bit               pend = 0;
  logic [AW-1:0]    pend_rd = '0;
  logic [WIDTH-1:0] pend_val = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // One clock: confirm the previous writeback landed, then match any new retire/illegal to the scoreboard.
  task automatic tick();
    bit  hit;
    sb_t e;
    hit = pend && !LO && WR && (RSM == pend_rd);
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      chk("wb_value", dbg_data, hit ? ManIn : pend_val);
      pend = 0;
    end
    if (retire || illegal) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {retire, illegal}, 2'b00);
      end else begin
        e = q.pop_front();
        chk("event_cycle", cyc, e.acc + 1);
        chk("event_kind", {retire, illegal}, e.ill ? 2'b01 : 2'b10);
        if (!e.ill) begin
          pend     = 1;
          pend_rd  = e.rd;
          pend_val = e.val;
          dbg_sel  = e.rd;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic man_wr(input int r, input logic [WIDTH-1:0] v);
    LO = 1'b0; WR = 1'b1; RSM = AW'(r); ManIn = v;
    tick();
    WR = 1'b0;
    arch[r] = v;
  endtask

  task automatic issue(input logic [5:0] op, input int rs, input int rt, input int rd,
                       input logic [4:0] sh, input logic [WIDTH-1:0] exp, input bit ill);
    sb_t e;
    e.rd = AW'(rd); e.val = exp; e.ill = ill; e.acc = cyc + 1;
    q.push_back(e);
    if (!ill) arch[rd] = exp;
    LO = 1'b1;
    ins.ins_valid = 1'b1;
    ins.INS = {op, 5'(rs), 5'(rt), 5'(rd), sh, 6'b0};
    tick();
    ins.ins_valid = 1'b0;
  endtask

  task automatic dump(input string nm);
    for (int r = 0; r < NREG; r++) begin
      dbg_sel = AW'(r);
      @(negedge clk);
      chk(nm, dbg_data, arch[r]);
    end
  endtask

  task automatic ov_pulse();
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins.ins_valid = 1'b0;
    ins.INS = '0;
    for (int r = 0; r < NREG; r++) arch[r] = '0;

    vt[0]  = '{OP_ADD, 32'd345,        32'd456,        5'd0, 32'd801,        1'b0, 1'b0};
    vt[1]  = '{OP_SUB, 32'd345,        32'd456,        5'd0, 32'hFFFFFF91,   1'b0, 1'b0};
    vt[2]  = '{OP_AND, 32'hF0F01234,   32'h0FF0FF00,   5'd0, 32'h00F01200,   1'b0, 1'b0};
    vt[3]  = '{OP_OR,  32'hF0F01234,   32'h0FF0FF00,   5'd0, 32'hFFF0FF34,   1'b0, 1'b0};
    vt[4]  = '{OP_NOR, 32'hF0F01234,   32'h0FF0FF00,   5'd0, 32'h000F00CB,   1'b0, 1'b0};
    vt[5]  = '{OP_XOR, 32'hF0F01234,   32'h0FF0FF00,   5'd0, 32'hFF00ED34,   1'b0, 1'b0};
    vt[6]  = '{OP_SLT, 32'hFFFFFFFB,   32'd3,          5'd0, 32'd1,          1'b0, 1'b0};
    vt[7]  = '{OP_SLT, 32'd3,          32'hFFFFFFFB,   5'd0, 32'd0,          1'b0, 1'b0};
    vt[8]  = '{OP_ADD, 32'h7FFFFFFF,   32'd1,          5'd0, 32'h80000000,   1'b1, 1'b0};
    vt[9]  = '{OP_SUB, 32'h80000000,   32'd1,          5'd0, 32'h7FFFFFFF,   1'b1, 1'b0};
    vt[10] = '{OP_ADD, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd0,          1'b0, 1'b0};
    vt[11] = '{6'h3F,  32'd1,          32'd2,          5'd0, 32'd0,          1'b0, 1'b1};
`ifdef CPU_SHIFT_OPS_EN
    vt[12] = '{OP_SLL, 32'd5,          32'h80000001,   5'd4, 32'h00000010,   1'b0, 1'b0};
    vt[13] = '{OP_SRL, 32'd5,          32'h80000001,   5'd4, 32'h08000000,   1'b0, 1'b0};
`else
    vt[12] = '{OP_SLL, 32'd5,          32'h80000001,   5'd4, 32'd0,          1'b0, 1'b1};
    vt[13] = '{OP_SRL, 32'd5,          32'h80000001,   5'd4, 32'd0,          1'b0, 1'b1};
`endif

    // Reset state, with LO high to show ins_ready is held low under reset.
    LO = 1'b1;
    #12;
    chk("rst_ins_ready", ins.ins_ready, 1'b0);
    chk("rst_ov", OV, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    reset = 1'b1;
    LO = 1'b0;
    dump("rst_regs");

    // Opcode table: operands in r3/r4, result in r5.
    for (int i = 0; i < 14; i++) begin
      ov_pulse();
      man_wr(3, vt[i].a);
      man_wr(4, vt[i].b);
      issue(vt[i].op, 3, 4, 5, vt[i].sh, vt[i].exp, vt[i].ill);
      idle(3);
      chk("vec_ov", OV, vt[i].ov);
      dbg_sel = 3'd5;
      @(negedge clk);
      chk("vec_rd", dbg_data, arch[5]);
    end

    // Preload then back-to-back add/sub, then a RAW chain through forwarding.
    ov_pulse();
    man_wr(0, 32'd345);
    man_wr(1, 32'd456);
    issue(OP_ADD, 0, 1, 2, 5'd0, 32'd801, 1'b0);
    issue(OP_SUB, 0, 1, 3, 5'd0, 32'hFFFFFF91, 1'b0);
    issue(OP_ADD, 0, 1, 2, 5'd0, 32'd801, 1'b0);
    issue(OP_ADD, 2, 1, 4, 5'd0, 32'd1257, 1'b0);
    idle(3);
    dump("fwd_regs");

    // Sticky overflow across an unrelated op, then clear.
    man_wr(5, 32'h7FFFFFFF);
    man_wr(6, 32'd1);
    issue(OP_ADD, 5, 6, 7, 5'd0, 32'h80000000, 1'b0);
    idle(3);
    chk("ov_set", OV, 1'b1);
    issue(OP_AND, 0, 1, 3, 5'd0, 32'd328, 1'b0);
    idle(3);
    chk("ov_sticky", OV, 1'b1);
    ov_pulse();
    chk("ov_cleared", OV, 1'b0);

    // Illegal opcode leaves rd alone.
    issue(6'h3F, 0, 1, 2, 5'd0, 32'd0, 1'b1);
    idle(3);
    dump("ill_regs");

    // Drop LO behind an add to r2 and collide a manual write with its drain.
    issue(OP_ADD, 0, 1, 2, 5'd0, 32'd801, 1'b0);
    LO = 1'b0;
    ins.ins_valid = 1'b1;
    ins.INS = {OP_ADD, 5'd0, 5'd1, 5'd6, 5'd0, 6'd0};
    #1;
    chk("lo_ins_ready", ins.ins_ready, 1'b0);
    tick();
    man_wr(2, 32'd9);
    ins.ins_valid = 1'b0;
    idle(3);
    dump("mode_regs");

    // Clear and a fresh overflow in the same cycle: set wins.
    issue(OP_ADD, 5, 6, 7, 5'd0, 32'h80000000, 1'b0);
    tick();
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    chk("ov_clr_vs_set", OV, 1'b1);
    idle(2);

    // Reset with an add in flight: nothing retires, everything clears.
    issue(OP_ADD, 0, 1, 2, 5'd0, 32'd801, 1'b0);
    #1;
    reset = 1'b0;
    q.delete();
    pend = 0;
    for (int r = 0; r < NREG; r++) arch[r] = '0;
    #1;
    chk("midrst_retire", retire, 1'b0);
    chk("midrst_ready", ins.ins_ready, 1'b0);
    chk("midrst_ov", OV, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(4);
    chk("midrst_ov_after", OV, 1'b0);
    dump("midrst_regs");

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_core_pipe.md
Name: cpu_core_pipe

Overview:
- Parametrised successor to the team's single-cycle 8×32 CPU datapath.
- Generic register-file width and depth, a two-stage pipeline (read / execute-writeback) with forwarding, and an instruction valid/ready handshake.
- Sticky overflow, an illegal-opcode flag, and one debug read port replace the fixed per-register outputs.
- Retains manual-load mode (LO=0) for preloading registers from ManIn.

Parameters:
- WIDTH, 32, datapath and register width (8..64).
- NREG, 8, register count; power of two, 2..32.
- AW, $clog2(NREG), register index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- LO  in  1  mode: 0 = manual load, 1 = operating
- WR  in  1  manual write enable (honoured only when LO=0)
- RSM  in  AW  manual write register select
- ManIn  in  WIDTH  manual write data
- ins_valid  in  1  INS carries an instruction
- INS  in  32  instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6]
- ins_ready  out  1  core accepts INS this cycle
- ov_clr  in  1  clears sticky OV
- OV  out  1  sticky signed overflow
- illegal  out  1  one-cycle pulse on an undefined opcode
- retire  out  1  one-cycle pulse on each register writeback
- dbg_sel  in  AW  debug register select
- dbg_data  out  WIDTH  combinational read of reg[dbg_sel]

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, both pipeline stages invalid; OV=0, illegal=0, retire=0, ins_ready=0.
- ins_ready = LO (registered copy of LO is not used). An instruction is accepted when ins_valid & ins_ready at the clock edge.
- Register fields use their low AW bits; high bits are ignored.
- Opcodes:
  - 000000 add, 000100 sub, 000001 and, 000010 or, 000011 nor
  - 000101 slt (signed; result 1 or 0), 000110 xor
  - Any other opcode (except those under the optional feature): illegal.
- Stage 1 (the cycle after accept): decode and operand read. If stage 2 is writing rs or rt, the operand is forwarded from the stage-2 result.
- Stage 2: ALU operation; reg[rd] is written at the end of the cycle, with retire=1 that cycle.
- Latency: an instruction accepted at edge N is visible on dbg_data after edge N+2.
- Throughput: one instruction per cycle, no stalls.
- Back-to-back RAW dependencies resolve through forwarding alone.
- Arithmetic is modulo 2^WIDTH.
- OV is set when add/sub overflows in signed arithmetic. It stays set until ov_clr=1 or reset. If ov_clr and a new overflow occur in the same cycle, OV=1.
- Illegal opcode: no register write, retire=0, illegal=1 in the stage-2 cycle.
- Manual write: LO=0 & WR=1 writes reg[RSM] <= ManIn at the clock edge.
- Dropping LO while instructions are in flight: no new accepts; stages already holding instructions drain and write normally.
- Drain writeback and manual write to the same register in the same cycle: the manual write wins and retire is still pulsed. Different registers: both writes occur.
- reg0 is an ordinary writable register (not hardwired to zero).
- Asserting reset mid-pipeline: in-flight instructions are discarded, no writeback.

Optional Feature:
- Macro: CPU_SHIFT_OPS_EN.
- Defined: opcode 000111 = sll (rd = rt << shamt) and 001000 = srl (rd = rt >> shamt, logical). shamt uses its low $clog2(WIDTH) bits; OV is unaffected.
- Undefined: 000111 and 001000 are illegal.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_XOR, OP_SLL, OP_SRL)
  - instruction field bit-position constants
  - the ALU-op enum typedef
- One sub-module: cpu_alu, a combinational WIDTH-parametrised ALU producing result, overflow and illegal.
- The register file and pipeline registers stay in cpu_core_pipe.

Test Plan:
- Preload, then add/sub: with LO=0, WR r0=345, r1=456; set LO=1 and issue add r2 and sub r3. Expect r2=801 and r3=32'hFFFFFF91, each with retire pulsed 2 cycles after accept.
- Forwarding: issue add r2=r0+r1, then on the next cycle add r4=r2+r1. Expect r4=1257 with no bubble.
- Overflow: preload r5=32'h7FFFFFFF and r6=1; add r7. Expect r7=32'h80000000 and OV=1, held across later ops until ov_clr; then OV=0.
- Illegal opcode: issue op 111111 (and 000111 with the macro undefined). Expect illegal pulsed once, rd unchanged, retire=0.
- Mode-switch conflict: issue add to r2, drop LO the next cycle and manually write r2=9 in the same cycle as the drain writeback. Expect r2=9 and ins_ready=0.
- Reset mid-flight: pull reset low one cycle after accepting add r2. Expect all registers 0, OV=0, and no retire after release.
